// File: rtl/puf_session_fsm_if.sv
// Handshake bundle between the PUF session sequencer and the UART, challenge/ID
// data path, PUF array and response FIFO.
interface puf_session_fsm_if;
    logic rx_valid;
    logic id_requested;
    logic store_challenge;
    logic puf_start;
    logic puf_done;
    logic fifo_empty;
    logic fifo_rd_en;
    logic data_sel;
    logic tx_start;
    logic tx_done;
    logic busy;
    logic timeout_err;

    modport master (
        input  rx_valid, id_requested, puf_done, fifo_empty, tx_done,
        output store_challenge, puf_start, fifo_rd_en, data_sel, tx_start, busy, timeout_err
    );

    modport slave (
        output rx_valid, id_requested, puf_done, fifo_empty, tx_done,
        input  store_challenge, puf_start, fifo_rd_en, data_sel, tx_start, busy, timeout_err
    );
endinterface

// File: rtl/puf_session_fsm.sv
// Sequences one UART transaction of the PUF core: either echo the ID byte, or
// latch a challenge, run the PUF and stream NUM_RESP_BYTES responses out.
module puf_session_fsm #(
    parameter int NUM_RESP_BYTES = 4,
    parameter int PUF_TIMEOUT    = 1024
) (
    input  logic              clk,
    input  logic              reset,
    puf_session_fsm_if.master bus
);
    localparam int              CW        = $clog2(PUF_TIMEOUT) + 1;
    localparam logic [CW-1:0]   TO_LAST   = CW'(PUF_TIMEOUT - 1);
    localparam logic [CW-1:0]   TO_ONE    = CW'(1);
    localparam logic [7:0]      RESP_LAST = 8'(NUM_RESP_BYTES - 1);

    typedef enum logic [3:0] {
        IDLE     = 4'd0,
        SEND_ID  = 4'd1,
        ID_WAIT  = 4'd2,
        LOAD     = 4'd3,
        START    = 4'd4,
        WAIT_PUF = 4'd5,
        POP      = 4'd6,
        POP_WAIT = 4'd7,
        TX       = 4'd8,
        TX_WAIT  = 4'd9
    } state_t;

    state_t          state_r;
    state_t          next_state;
    logic [CW-1:0]   to_cnt_r;
    logic [CW-1:0]   to_next;
    logic [7:0]      resp_cnt_r;
    logic [7:0]      resp_next;
    logic            err_next;

    logic            store_challenge_r;
    logic            puf_start_r;
    logic            pop_r;
    logic            data_sel_r;
    logic            tx_start_r;
    logic            busy_r;
    logic            timeout_err_r;

    function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
        if (&v) begin
            return v;
        end else begin
            return v + TO_ONE;
        end
    endfunction

    // Next-state, counter and error-flag decode.
    always_comb begin
        next_state = state_r;
        to_next    = to_cnt_r;
        resp_next  = resp_cnt_r;
        err_next   = timeout_err_r;
        case (state_r)
            IDLE: begin
                if (bus.rx_valid) begin
                    err_next = 1'b0;
                    if (bus.id_requested) begin
                        next_state = SEND_ID;
                    end else begin
                        next_state = LOAD;
                    end
                end else begin
                    next_state = IDLE;
                end
            end
            SEND_ID: next_state = ID_WAIT;
            ID_WAIT: begin
                if (bus.tx_done) begin
                    next_state = IDLE;
                end else begin
                    next_state = ID_WAIT;
                end
            end
            LOAD: begin
                next_state = START;
                resp_next  = 8'd0;
            end
            START: begin
                next_state = WAIT_PUF;
                to_next    = '0;
            end
            WAIT_PUF: begin
                if (bus.puf_done) begin
                    next_state = POP;
                    to_next    = '0;
                end else if (to_cnt_r == TO_LAST) begin
                    next_state = IDLE;
                    err_next   = 1'b1;
                end else begin
                    to_next = sat_inc(to_cnt_r);
                end
            end
            POP: begin
                if (!bus.fifo_empty) begin
                    next_state = POP_WAIT;
                end else if (to_cnt_r == TO_LAST) begin
                    next_state = IDLE;
                    err_next   = 1'b1;
                end else begin
                    to_next = sat_inc(to_cnt_r);
                end
            end
            POP_WAIT: next_state = TX;
            TX:       next_state = TX_WAIT;
            TX_WAIT: begin
                if (bus.tx_done) begin
                    resp_next = resp_cnt_r + 8'd1;
                    if (resp_cnt_r == RESP_LAST) begin
                        next_state = IDLE;
                    end else begin
                        next_state = POP;
                        to_next    = '0;
                    end
                end else begin
                    next_state = TX_WAIT;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    // State and counter registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r    <= IDLE;
            to_cnt_r   <= '0;
            resp_cnt_r <= 8'd0;
        end else begin
            state_r    <= next_state;
            to_cnt_r   <= to_next;
            resp_cnt_r <= resp_next;
        end
    end

    // Output registers, decoded from the state being entered so they align with it.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            store_challenge_r <= 1'b0;
            puf_start_r       <= 1'b0;
            pop_r             <= 1'b0;
            data_sel_r        <= 1'b0;
            tx_start_r        <= 1'b0;
            busy_r            <= 1'b0;
            timeout_err_r     <= 1'b0;
        end else begin
            store_challenge_r <= (next_state == LOAD);
            puf_start_r       <= (next_state == START);
            pop_r             <= (next_state == POP);
            data_sel_r        <= (next_state == POP) || (next_state == POP_WAIT) ||
                                 (next_state == TX)  || (next_state == TX_WAIT);
            tx_start_r        <= (next_state == SEND_ID) || (next_state == TX);
            busy_r            <= (next_state != IDLE);
            timeout_err_r     <= err_next;
        end
    end

    assign bus.store_challenge = store_challenge_r;
    assign bus.puf_start       = puf_start_r;
    // Pop lands on the first POP cycle the FIFO reports data, so the byte is
    // on fifo_out by the TX cycle two clocks later.
    assign bus.fifo_rd_en      = pop_r & ~bus.fifo_empty;
    assign bus.data_sel        = data_sel_r;
    assign bus.tx_start        = tx_start_r;
    assign bus.busy            = busy_r;
    assign bus.timeout_err     = timeout_err_r;
endmodule
